// File: rtl/vga_frame_timer.sv
// Purpose: 640x480 VGA pixel timing master; scan position out, colour sampled back, registered DAC drive.
// Latency: DAC colour/sync/blank for position (x,y) appear one pixel (2 Clk) after DrawX/DrawY show (x,y).
// Backpressure: none; free-running raster, the mapper must answer combinationally within a pixel.
module vga_frame_timer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_B = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_E = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_B = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_E = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic       toggle;
    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       visible;
    logic       hs_active;
    logic       vs_active;
    logic       line_end;
    logic       frame_end;

    assign pix_en    = toggle;
    assign line_end  = (hc == H_LAST);
    assign frame_end = (vc == V_LAST);

    // Decoded from the current (pre-increment) position so the output stage
    // registers the attributes of the pixel the mapper is colouring right now.
    assign visible   = (hc < H_VIS) && (vc < V_VIS);
    assign hs_active = (hc >= H_SYNC_B) && (hc < H_SYNC_E);
    assign vs_active = (vc >= V_SYNC_B) && (vc < V_SYNC_E);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            toggle      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            toggle <= ~toggle;
            if (pix_en) begin
                if (line_end) begin
                    hc <= '0;
                    vc <= frame_end ? 10'd0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
                VGA_HS      <= ~hs_active;
                VGA_VS      <= ~vs_active;
                VGA_BLANK_N <= visible;
                VGA_R       <= visible ? Red   : 8'd0;
                VGA_G       <= visible ? Green : 8'd0;
                VGA_B       <= visible ? Blue  : 8'd0;
            end
        end
    end

    // Decoded from registers only; toggle is 0 through reset, so no strobe there.
    assign frame_start = pix_en && (hc == 10'd0) && (vc == 10'd0);

    assign DrawX      = hc;
    assign DrawY      = vc;
    assign VGA_CLK    = toggle;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: doc/vga_frame_timer.md
Name: vga_frame_timer

Overview:
- Pixel-timing master for the 640x480 VGA display path.
- Generates the pixel scan position (DrawX/DrawY) consumed by the colour mapper, samples the mapper's combinational Red/Green/Blue back at each pixel, and drives the registered VGA DAC outputs with sync and blanking aligned to the colour.
- Also emits a one-cycle frame-start strobe for game/ball state update logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- Clk  input  1  50 MHz system clock
- Reset  input  1  synchronous, active-high reset
- Red  input  8  mapper colour for current DrawX/DrawY
- Green  input  8  mapper colour for current DrawX/DrawY
- Blue  input  8  mapper colour for current DrawX/DrawY
- DrawX  output  10  current horizontal scan position (0..H_TOTAL-1)
- DrawY  output  10  current vertical scan position (0..V_TOTAL-1)
- frame_start  output  1  one-Clk strobe at start of pixel (0,0)
- VGA_CLK  output  1  25 MHz pixel clock (Clk/2)
- VGA_HS  output  1  horizontal sync, active low
- VGA_VS  output  1  vertical sync, active low
- VGA_BLANK_N  output  1  high during visible pixels
- VGA_SYNC_N  output  1  tied 0 (no sync-on-green)
- VGA_R  output  8  DAC red
- VGA_G  output  8  DAC green
- VGA_B  output  8  DAC blue

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high, applied on the Clk rising edge.
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). All compares are unsigned 10-bit.
- Pixel enable:
  - A toggle register flips every Clk; pix_en = toggle.
  - VGA_CLK = toggle.
  - Each pixel occupies 2 Clk cycles.
- Reset values: toggle=0, hc=0, vc=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, frame_start=0.
- Counters: DrawX=hc and DrawY=vc, both registered.
  - On pix_en: if hc==H_TOTAL-1, then hc<=0 and vc advances; else hc<=hc+1.
  - vc wraps from V_TOTAL-1 to 0 when hc wraps.
- visible = (hc < H_VISIBLE) && (vc < V_VISIBLE), evaluated on the pre-increment hc/vc.
- Output stage (registered on pix_en, sampled from the pre-increment hc/vc and the current Red/Green/Blue):
  - VGA_R/G/B <= visible ? Red/Green/Blue : 0
  - VGA_BLANK_N <= visible
  - VGA_HS <= ~(hc >= H_VISIBLE+H_FRONT && hc < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for hc 656..751
  - VGA_VS <= ~(vc >= V_VISIBLE+V_FRONT && vc < V_VISIBLE+V_FRONT+V_SYNC), i.e. low for vc 490..491
- Latency: the DAC outputs for position (x,y) appear one pixel (2 Clk) after DrawX/DrawY present (x,y). Sync, blank and colour are mutually aligned.
- Outputs hold their values on non-pix_en cycles.
- frame_start: high for exactly one Clk, in the pix_en cycle where hc==0 && vc==0. It does not fire in the reset cycle itself.
  - After Reset deasserts: Clk 1 has toggle=0; Clk 2 has pix_en=1 with hc=vc=0, so frame_start=1.
- Reset mid-frame: all state returns to reset values on the next Clk edge regardless of position. No partial-line continuation.
- Mapper colour while not visible is ignored; the DAC is forced to 0.

Test Plan:
- Reset values: hold Reset 3 Clk -> VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, DrawX=0, DrawY=0, VGA_CLK=0. Release Reset -> frame_start high exactly on the 2nd Clk after release.
- Pixel pass-through: drive Red=8'hA5, Green=8'h3C, Blue=8'h0F constant -> at DrawX=0, DrawY=0, 2 Clk later VGA_R/G/B=A5/3C/0F and VGA_BLANK_N=1.
- Blanking: Red=Green=Blue=8'hFF -> for DrawX>=640 or DrawY>=480, VGA_R/G/B=0 and VGA_BLANK_N=0 one pixel later. Pixel 639 is output as FF, pixel 640 as 0.
- Horizontal sync: on any line, VGA_HS low for exactly 192 Clk (96 pixels), going low 2 Clk after DrawX becomes 656. Line period = 1600 Clk; DrawX wraps 799->0 with DrawY+1.
- Vertical sync and frame: VGA_VS low for exactly 2 lines (3200 Clk) while the registered vc is 490..491. frame_start period = 840000 Clk; DrawY wraps 524->0.
- Reset mid-frame: assert Reset at DrawX=300, DrawY=200 for 1 Clk -> next Clk all outputs are at reset values and the counters restart from (0,0). frame_start follows 2 Clk after release.
